// File: rtl/var_select_pkg.sv
// Shared definitions for the variable selector: FSM states, default widths and
// the derived accumulator/product widths.
package var_select_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_SCALE   = 3'd2,
        ST_SCAN    = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_e;

    localparam int DEF_MAX_CAND      = 8;
    localparam int DEF_VAR_WIDTH     = 16;
    localparam int DEF_BREAK_WIDTH   = 16;
    localparam int DEF_BUFFER_DEPTH  = 2048;
    localparam int DEF_M_TABLE_WIDTH = 32;
    localparam int RAND_WIDTH        = 32;

    // Sum of up to max_cand weights of (m_table_width+1) bits each.
    function automatic int sum_width(input int m_table_width, input int max_cand);
        return m_table_width + 1 + $clog2(max_cand);
    endfunction

    function automatic int prod_width(input int m_table_width, input int max_cand);
        return sum_width(m_table_width, max_cand) + RAND_WIDTH;
    endfunction

    localparam int SUM_WIDTH  = sum_width(DEF_M_TABLE_WIDTH, DEF_MAX_CAND);
    localparam int PROD_WIDTH = prod_width(DEF_M_TABLE_WIDTH, DEF_MAX_CAND);

endpackage

// File: rtl/var_select_if.sv
// Candidate input stream and selection output handshake of the variable selector.
interface var_select_if #(
    parameter int VAR_WIDTH   = 16,
    parameter int BREAK_WIDTH = 16
);
    logic                   cand_valid_i;
    logic                   cand_ready_o;
    logic [VAR_WIDTH-1:0]   cand_var_i;
    logic [BREAK_WIDTH-1:0] cand_break_i;
    logic                   cand_last_i;
    logic                   sel_valid_o;
    logic                   sel_ready_i;
    logic [VAR_WIDTH-1:0]   sel_var_o;

    modport master (
        output cand_valid_i, cand_var_i, cand_break_i, cand_last_i, sel_ready_i,
        input  cand_ready_o, sel_valid_o, sel_var_o
    );

    modport slave (
        input  cand_valid_i, cand_var_i, cand_break_i, cand_last_i, sel_ready_i,
        output cand_ready_o, sel_valid_o, sel_var_o
    );
endinterface

// File: rtl/var_select_prefix_scan.sv
// Walks the weight buffer one entry per cycle and reports the first index whose
// running prefix sum exceeds the threshold; the last stored entry is taken as fallback.
module prefix_scan #(
    parameter int MAX_CAND = 8,
    parameter int W_WIDTH  = 33,
    parameter int SUM_W    = 36
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                active,
    input  logic [MAX_CAND-1:0][W_WIDTH-1:0]    weights,
    input  logic [$clog2(MAX_CAND+1)-1:0]       count,
    input  logic [SUM_W-1:0]                    threshold,
    output logic [$clog2(MAX_CAND)-1:0]         idx,
    output logic                                done
);
    localparam int CNT_W = $clog2(MAX_CAND + 1);
    localparam int IDX_W = $clog2(MAX_CAND);

    logic [IDX_W-1:0] idx_r;
    logic [SUM_W-1:0] prefix_r;
    logic [SUM_W-1:0] prefix_next_s;
    logic             last_s;
    logic             hit_s;

    // Prefix including the current entry and the stop condition for this cycle.
    always_comb begin
        prefix_next_s = prefix_r + SUM_W'(weights[idx_r]);
        last_s        = (CNT_W'(idx_r) + CNT_W'(1)) >= count;
        hit_s         = (prefix_next_s > threshold) || last_s;
    end

    // Scan position and running prefix; cleared before each new scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r    <= '0;
            prefix_r <= '0;
        end else if (clear) begin
            idx_r    <= '0;
            prefix_r <= '0;
        end else if (active && !hit_s) begin
            idx_r    <= idx_r + IDX_W'(1);
            prefix_r <= prefix_next_s;
        end
    end

    assign idx  = idx_r;
    assign done = active && hit_s;
endmodule

// File: rtl/var_select.sv
// Variable selector: collects a clause's candidates, weights each by 1/m from an
// external table and draws one at random by weight; a break-0 variable wins outright.
module var_select
    import var_select_pkg::*;
#(
    parameter int MAX_CAND      = DEF_MAX_CAND,
    parameter int VAR_WIDTH     = DEF_VAR_WIDTH,
    parameter int BREAK_WIDTH   = DEF_BREAK_WIDTH,
    parameter int BUFFER_DEPTH  = DEF_BUFFER_DEPTH,
    parameter int M_TABLE_WIDTH = DEF_M_TABLE_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    var_select_if.slave                     bus,
    output logic                            m_en_o,
    output logic [$clog2(BUFFER_DEPTH)-1:0] m_addr_o,
    input  logic [M_TABLE_WIDTH:0]          m_data_i,
    input  logic [RAND_WIDTH-1:0]           rand_i,
    output logic                            err_overflow_o
);
    localparam int ADDR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W  = $clog2(MAX_CAND + 1);
    localparam int IDX_W  = $clog2(MAX_CAND);
    localparam int W_W    = M_TABLE_WIDTH + 1;
    localparam int SUM_W  = sum_width(M_TABLE_WIDTH, MAX_CAND);
    localparam int PROD_W = prod_width(M_TABLE_WIDTH, MAX_CAND);

    state_e                            state_r, state_s;
    logic [CNT_W-1:0]                  cand_cnt_r, n_stored_r;
    logic [MAX_CAND-1:0][W_W-1:0]      w_r;
    logic [MAX_CAND-1:0][VAR_WIDTH-1:0] var_r;
    logic [SUM_W-1:0]                  sum_r, thr_r;
    logic                              pend_r, free_r, sel_valid_r, err_r;
    logic [VAR_WIDTH-1:0]              pend_var_r, free_var_r, sel_var_r;
    logic                              accept_s, slot_ok_s, lookup_s, scan_done_s;
    logic [IDX_W-1:0]                  scan_idx_s;

    // Acceptance and table lookup for the candidate on the bus this cycle.
    always_comb begin
        accept_s  = bus.cand_valid_i && (state_r == ST_COLLECT);
        slot_ok_s = cand_cnt_r < CNT_W'(MAX_CAND);
        lookup_s  = accept_s && slot_ok_s && (bus.cand_break_i != '0);
        m_en_o    = lookup_s;
        if (!lookup_s) begin
            m_addr_o = '0;
        end else if (bus.cand_break_i > BREAK_WIDTH'(BUFFER_DEPTH - 1)) begin
            m_addr_o = ADDR_W'(BUFFER_DEPTH - 1);
        end else begin
            m_addr_o = bus.cand_break_i[ADDR_W-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_COLLECT: if (accept_s && bus.cand_last_i) state_s = ST_DRAIN;
                        else state_s = ST_COLLECT;
            ST_DRAIN:   if (free_r) state_s = ST_OUTPUT;
                        else if (n_stored_r == '0 && !pend_r) state_s = ST_COLLECT;
                        else state_s = ST_SCALE;
            ST_SCALE:   state_s = ST_SCAN;
            ST_SCAN:    if (scan_done_s) state_s = ST_OUTPUT;
                        else state_s = ST_SCAN;
            ST_OUTPUT:  if (bus.sel_ready_i) state_s = ST_COLLECT;
                        else state_s = ST_OUTPUT;
            default:    state_s = ST_COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_COLLECT;
        else        state_r <= state_s;
    end

    // Clause datapath: weight capture, freebie latch, threshold and selection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_cnt_r  <= '0;
            n_stored_r  <= '0;
            w_r         <= '0;
            var_r       <= '0;
            sum_r       <= '0;
            thr_r       <= '0;
            pend_r      <= 1'b0;
            pend_var_r  <= '0;
            free_r      <= 1'b0;
            free_var_r  <= '0;
            sel_valid_r <= 1'b0;
            sel_var_r   <= '0;
            err_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                if (slot_ok_s) cand_cnt_r <= cand_cnt_r + CNT_W'(1);
                else           err_r      <= 1'b1;
                if (slot_ok_s && bus.cand_break_i == '0 && !free_r) begin
                    free_r     <= 1'b1;
                    free_var_r <= bus.cand_var_i;
                end
            end
            // Table data arrives one cycle after the lookup; the var travels with it.
            pend_r <= lookup_s;
            if (lookup_s) pend_var_r <= bus.cand_var_i;
            if (pend_r) begin
                w_r[n_stored_r[IDX_W-1:0]]   <= m_data_i;
                var_r[n_stored_r[IDX_W-1:0]] <= pend_var_r;
                n_stored_r                   <= n_stored_r + CNT_W'(1);
                sum_r                        <= sum_r + SUM_W'(m_data_i);
            end
            if (state_r == ST_SCALE) begin
                thr_r <= SUM_W'((PROD_W'(sum_r) * PROD_W'(rand_i)) >> RAND_WIDTH);
            end
            if (state_r == ST_DRAIN && free_r) begin
                sel_valid_r <= 1'b1;
                sel_var_r   <= free_var_r;
            end else if (state_r == ST_SCAN && scan_done_s) begin
                sel_valid_r <= 1'b1;
                sel_var_r   <= var_r[scan_idx_s];
            end
            if (state_r == ST_OUTPUT && bus.sel_ready_i) begin
                sel_valid_r <= 1'b0;
                cand_cnt_r  <= '0;
                n_stored_r  <= '0;
                w_r         <= '0;
                sum_r       <= '0;
                free_r      <= 1'b0;
                pend_r      <= 1'b0;
            end
        end
    end

    prefix_scan #(
        .MAX_CAND (MAX_CAND),
        .W_WIDTH  (W_W),
        .SUM_W    (SUM_W)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state_r == ST_SCALE),
        .active    (state_r == ST_SCAN),
        .weights   (w_r),
        .count     (n_stored_r),
        .threshold (thr_r),
        .idx       (scan_idx_s),
        .done      (scan_done_s)
    );

    assign bus.cand_ready_o = (state_r == ST_COLLECT);
    assign bus.sel_valid_o  = sel_valid_r;
    assign bus.sel_var_o    = sel_var_r;
    assign err_overflow_o   = err_r;
endmodule

// File: tb/tb_var_select.sv
// Self-checking bench for var_select: 1/m table model, directed corner clauses,
// randomized clauses checked against a weighted-draw reference model.
module tb_var_select;
    logic        clk;
    logic        rst_n;
    logic        m_en_o;
    logic [10:0] m_addr_o;
    logic [32:0] m_data_i;
    logic [31:0] rand_i;
    logic        err_overflow_o;

    int          n_tests;
    int          n_fail;
    int          cv [16];
    int          cb [16];
    logic [31:0] rnd;
    logic        exp_err;

    var_select_if bus ();

    var_select dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .m_en_o         (m_en_o),
        .m_addr_o       (m_addr_o),
        .m_data_i       (m_data_i),
        .rand_i         (rand_i),
        .err_overflow_o (err_overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1/m table: ceil(2^32/m), one cycle of latency.
    always @(posedge clk) begin
        if (m_en_o && m_addr_o != 11'd0)
            m_data_i <= 33'(((64'd1 << 32) + 64'(m_addr_o) - 64'd1) / 64'(m_addr_o));
        else
            m_data_i <= 33'd0;
    end

    // Reference: freebie wins, else first prefix above (sum*rand)>>32, else last eligible.
    task automatic model(input int n, output int ev, output int el);
        logic [71:0] w [8];
        logic [71:0] sum, thr, pre;
        int ne, m;
        ne = (n < 8) ? n : 8;
        for (int i = 0; i < ne; i++) begin
            if (cb[i] == 0) begin
                ev = cv[i];
                el = 2;
                return;
            end
        end
        sum = 72'd0;
        for (int i = 0; i < ne; i++) begin
            m    = (cb[i] > 2047) ? 2047 : cb[i];
            w[i] = ((72'd1 << 32) + 72'(m) - 72'd1) / 72'(m);
            sum  = sum + w[i];
        end
        thr = (sum * 72'(rnd)) >> 32;
        pre = 72'd0;
        for (int i = 0; i < ne; i++) begin
            pre = pre + w[i];
            if (pre > thr) begin
                ev = cv[i];
                el = i + 4;
                return;
            end
        end
        ev = cv[ne-1];
        el = ne + 3;
    endtask

    task automatic drive_cands(input int n);
        logic        exp_en;
        logic [10:0] exp_addr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cand_valid_i = 1'b1;
            bus.cand_var_i   = 16'(cv[i]);
            bus.cand_break_i = 16'(cb[i]);
            bus.cand_last_i  = (i == n - 1);
            #1;
            exp_en   = (i < 8) && (cb[i] != 0);
            exp_addr = (cb[i] > 2047) ? 11'd2047 : 11'(cb[i]);
            n_tests++;
            if (bus.cand_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL cand_ready[%0d]: got %b expected 1", i, bus.cand_ready_o);
            end
            n_tests++;
            if (m_en_o !== exp_en || (exp_en && m_addr_o !== exp_addr)) begin
                n_fail++;
                $display("FAIL lookup[%0d]: got en=%b addr=%0d expected en=%b addr=%0d",
                         i, m_en_o, m_addr_o, exp_en, exp_addr);
            end
        end
        @(negedge clk);
        bus.cand_valid_i = 1'b0;
        bus.cand_last_i  = 1'b0;
    endtask

    task automatic run_clause(input int n, input int hold, input string name);
        int ev, el, cyc;
        logic [15:0] held;
        model(n, ev, el);
        rand_i = rnd;
        drive_cands(n);
        cyc = 1;
        while (bus.sel_valid_o !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (bus.sel_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: got no sel_valid expected one after %0d cycles", name, el);
            return;
        end
        if (n > 8) exp_err = 1'b1;
        if (cyc != el) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, el);
        end
        n_tests++;
        if (bus.sel_var_o !== 16'(ev)) begin
            n_fail++;
            $display("FAIL %s sel_var: got %0d expected %0d", name, bus.sel_var_o, ev);
        end
        n_tests++;
        if (err_overflow_o !== exp_err) begin
            n_fail++;
            $display("FAIL %s err_overflow: got %b expected %b", name, err_overflow_o, exp_err);
        end
        held = 16'(ev);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_tests++;
            if (bus.sel_valid_o !== 1'b1 || bus.sel_var_o !== held || bus.cand_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold[%0d]: got v=%b var=%0d rdy=%b expected v=1 var=%0d rdy=0",
                         name, h, bus.sel_valid_o, bus.sel_var_o, bus.cand_ready_o, held);
            end
        end
        bus.sel_ready_i = 1'b1;
        @(negedge clk);
        bus.sel_ready_i = 1'b0;
        n_tests++;
        if (bus.sel_valid_o !== 1'b0 || bus.cand_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: got v=%b rdy=%b expected v=0 rdy=1",
                     name, bus.sel_valid_o, bus.cand_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_err = 1'b0;
        n_tests++;
        if (bus.sel_valid_o !== 1'b0 || bus.sel_var_o !== 16'd0 || m_en_o !== 1'b0 ||
            m_addr_o !== 11'd0 || err_overflow_o !== 1'b0 || bus.cand_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: got v=%b var=%0d en=%b addr=%0d err=%b rdy=%b expected 0 0 0 0 0 1",
                     bus.sel_valid_o, bus.sel_var_o, m_en_o, m_addr_o, err_overflow_o, bus.cand_ready_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        cv[0] = 100; cv[1] = 200; cb[0] = 1; cb[1] = 1;
        rnd = 32'h8000_0000;
        run_clause(2, 0, "thr_2p32");
        rnd = 32'h7FFF_FFFF;
        run_clause(2, 0, "thr_below");
        cv[0] = 7; cv[1] = 9; cv[2] = 11; cb[0] = 3; cb[1] = 0; cb[2] = 5;
        rnd = $urandom;
        run_clause(3, 0, "freebie");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            cv[i] = $urandom_range(0, 65535);
            cb[i] = $urandom_range(1, 3000);
        end
        rnd = $urandom;
        run_clause(10, 0, "overflow");
    endtask

    task automatic test_backpressure();
        cv[0] = 21; cv[1] = 22; cv[2] = 23; cb[0] = 4; cb[1] = 2; cb[2] = 9;
        rnd = $urandom;
        run_clause(3, 5, "backpressure");
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < 8; i++) begin
            cv[i] = 300 + i;
            cb[i] = 1;
        end
        rnd    = 32'hFFFF_FFFF;
        rand_i = rnd;
        drive_cands(8);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_err = 1'b0;
        n_tests++;
        if (bus.sel_valid_o !== 1'b0 || bus.cand_ready_o !== 1'b1 || err_overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_scan: got v=%b rdy=%b err=%b expected v=0 rdy=1 err=0",
                     bus.sel_valid_o, bus.cand_ready_o, err_overflow_o);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.sel_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stale[%0d]: got sel_valid=%b expected 0", i, bus.sel_valid_o);
            end
        end
        cv[0] = 41; cv[1] = 42; cb[0] = 1; cb[1] = 1;
        rnd = 32'h8000_0000;
        run_clause(2, 0, "after_reset");
    endtask

    task automatic test_random();
        int n, r;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                cv[i] = $urandom_range(0, 65535);
                r     = $urandom_range(0, 9);
                if (r == 0)      cb[i] = 0;
                else if (r == 1) cb[i] = $urandom_range(2048, 65535);
                else             cb[i] = $urandom_range(1, 40);
            end
            rnd = $urandom;
            run_clause(n, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        exp_err          = 1'b0;
        rst_n            = 1'b0;
        rand_i           = 32'd0;
        bus.cand_valid_i = 1'b0;
        bus.cand_var_i   = 16'd0;
        bus.cand_break_i = 16'd0;
        bus.cand_last_i  = 1'b0;
        bus.sel_ready_i  = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_overflow();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
